// File: rtl/seq_divider_pkg.sv
// div_pkg: FSM state encodings and counter sizing for seq_divider.
package div_pkg;
  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_CALC = 2'd1;
  localparam logic [1:0] ST_FIX  = 2'd2;
  localparam logic [1:0] ST_DONE = 2'd3;
  function automatic int clog2(input int v);
    int r;
    r = 1;
    while ((1 << r) < v) r = r + 1;
    return r;
  endfunction
endpackage

// File: rtl/seq_divider_addsub.sv
// adder_subtractor: sum = a + b + cin when mode=0, a - b + cin when mode=1.
module adder_subtractor #(
  parameter int WIDTH = 9
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             mode,
  input  logic             cin,
  output logic [WIDTH-1:0] sum
);
  assign sum = a + (b ^ {WIDTH{mode}}) + WIDTH'(mode) + WIDTH'(cin);
endmodule

// File: rtl/seq_divider.sv
// seq_divider: iterative non-restoring unsigned divider, one quotient bit per clock.
module seq_divider
  import div_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder,
  output logic             div_by_zero,
  output logic             busy
);
  localparam int CW = clog2(WIDTH);
  logic [1:0]       r_state;
  logic [WIDTH:0]   r_r;
  logic [WIDTH-1:0] r_q, r_d, r_quot, r_rem;
  logic             r_dbz;
  logic [CW-1:0]    r_cnt;
  logic             w_calc;
  logic [WIDTH:0]   w_s, w_sum;
  assign w_calc      = r_state == ST_CALC;
  assign w_s         = w_calc ? {r_r[WIDTH-1:0], r_q[WIDTH-1]} : r_r;
  assign in_ready    = r_state == ST_IDLE;
  assign out_valid   = r_state == ST_DONE;
  assign busy        = r_state != ST_IDLE;
  assign quotient    = r_quot;
  assign remainder   = r_rem;
  assign div_by_zero = r_dbz;
  // FIX reuses the adder in add mode to correct a negative final remainder
  adder_subtractor #(.WIDTH(WIDTH + 1)) u_addsub (
    .a   (w_s),
    .b   ({1'b0, r_d}),
    .mode(w_calc & ~r_r[WIDTH]),
    .cin (1'b0),
    .sum (w_sum)
  );
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= ST_IDLE;
      r_r     <= '0;
      r_q     <= '0;
      r_d     <= '0;
      r_cnt   <= '0;
      r_quot  <= '0;
      r_rem   <= '0;
      r_dbz   <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE: if (in_valid) begin
          r_d   <= divisor;
          r_q   <= dividend;
          r_r   <= '0;
          r_cnt <= CW'(WIDTH - 1);
          if (divisor == '0) begin
            r_quot  <= '1;
            r_rem   <= dividend;
            r_dbz   <= 1'b1;
            r_state <= ST_DONE;
          end else r_state <= ST_CALC;
        end
        ST_CALC: begin
          r_r     <= w_sum;
          r_q     <= {r_q[WIDTH-2:0], ~w_sum[WIDTH]};
          r_cnt   <= r_cnt - 1'b1;
          r_state <= r_cnt == '0 ? ST_FIX : ST_CALC;
        end
        ST_FIX: begin
          r_r     <= r_r[WIDTH] ? w_sum : r_r;
          r_quot  <= r_q;
          r_rem   <= r_r[WIDTH] ? w_sum[WIDTH-1:0] : r_r[WIDTH-1:0];
          r_dbz   <= 1'b0;
          r_state <= ST_DONE;
        end
        default: if (out_ready) r_state <= ST_IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_seq_divider.sv
// tb_seq_divider: directed and randomized checks of seq_divider against arithmetic / and %.
module tb_seq_divider;
  localparam int W = 8;
  logic clk = 0, rst = 1, in_valid = 0, out_ready = 0;
  logic in_ready, out_valid, div_by_zero, busy;
  logic [W-1:0] dividend = 0, divisor = 0, quotient, remainder;
  int errors = 0, checks = 0;

  seq_divider #(.WIDTH(W)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .dividend(dividend), .divisor(divisor), .out_valid(out_valid), .out_ready(out_ready),
    .quotient(quotient), .remainder(remainder), .div_by_zero(div_by_zero), .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic run_op(input logic [W-1:0] a, input logic [W-1:0] b,
                        output logic [W-1:0] q, output logic [W-1:0] r, output logic z,
                        output int lat, output bit to);
    int n;
    @(posedge clk); #1;
    in_valid = 1; dividend = a; divisor = b; out_ready = 1;
    n = 0;
    @(negedge clk);
    while (!in_ready && n < 50) begin @(negedge clk); n++; end
    @(posedge clk); #1;
    in_valid = 0; dividend = ~a; divisor = ~b;
    lat = 0; to = 1; q = 0; r = 0; z = 0;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      lat++;
      if (out_valid) begin q = quotient; r = remainder; z = div_by_zero; to = 0; break; end
    end
  endtask

  task automatic test_reset;
    rst = 1;
    repeat (3) @(posedge clk);
    #1 rst = 0;
    @(negedge clk);
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid got=%b exp=0", out_valid); end
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready got=%b exp=1", in_ready); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got=%b exp=0", busy); end
    checks++; if ({quotient, remainder, div_by_zero} !== '0) begin errors++;
      $display("FAIL reset_outputs got q=%0d r=%0d z=%b exp all 0", quotient, remainder, div_by_zero); end
  endtask

  task automatic test_directed;
    logic [W-1:0] va [5] = '{100, 255, 5, 255, 0};
    logic [W-1:0] vb [5] = '{7, 1, 9, 255, 3};
    logic [W-1:0] q, r; logic z; int lat; bit to;
    for (int i = 0; i < 5; i++) begin
      run_op(va[i], vb[i], q, r, z, lat, to);
      checks++; if (to) begin errors++; $display("FAIL dir_timeout %0d/%0d no out_valid", va[i], vb[i]); end
      checks++; if (q !== va[i] / vb[i] || r !== va[i] % vb[i]) begin errors++;
        $display("FAIL dir_result %0d/%0d got q=%0d r=%0d exp q=%0d r=%0d", va[i], vb[i], q, r, va[i] / vb[i], va[i] % vb[i]); end
      checks++; if (z !== 1'b0) begin errors++; $display("FAIL dir_dbz %0d/%0d got=%b exp=0", va[i], vb[i], z); end
      checks++; if (lat != W + 2) begin errors++; $display("FAIL dir_latency %0d/%0d got=%0d exp=%0d", va[i], vb[i], lat, W + 2); end
    end
  endtask

  task automatic test_div_zero;
    logic [W-1:0] q, r; logic z; int lat; bit to;
    run_op(37, 0, q, r, z, lat, to);
    checks++; if (to || q !== 8'hFF || r !== 8'd37 || z !== 1'b1) begin errors++;
      $display("FAIL dbz_result got q=%h r=%0d z=%b to=%b exp q=ff r=37 z=1", q, r, z, to); end
    checks++; if (lat != 1) begin errors++; $display("FAIL dbz_latency got=%0d exp=1", lat); end
  endtask

  task automatic test_backpressure;
    int n;
    @(posedge clk); #1;
    in_valid = 1; dividend = 200; divisor = 13; out_ready = 0;
    @(posedge clk); #1;
    in_valid = 0;
    n = 0;
    @(negedge clk);
    while (!out_valid && n < 50) begin @(negedge clk); n++; end
    checks++; if (!out_valid) begin errors++; $display("FAIL bp_timeout out_valid got=0 exp=1"); end
    for (int i = 0; i < 5; i++) begin
      checks++; if (out_valid !== 1'b1 || in_ready !== 1'b0 || quotient !== 8'd15 || remainder !== 8'd5) begin errors++;
        $display("FAIL bp_hold cycle %0d got v=%b rdy=%b q=%0d r=%0d exp v=1 rdy=0 q=15 r=5", i, out_valid, in_ready, quotient, remainder); end
      @(negedge clk);
    end
    out_ready = 1;
    @(posedge clk); #1;
    out_ready = 0;
    @(negedge clk);
    checks++; if (out_valid !== 1'b0 || in_ready !== 1'b1 || busy !== 1'b0) begin errors++;
      $display("FAIL bp_handoff got v=%b rdy=%b busy=%b exp v=0 rdy=1 busy=0", out_valid, in_ready, busy); end
  endtask

  task automatic test_reset_mid;
    logic [W-1:0] q, r; logic z; int lat; bit to; bit seen;
    @(posedge clk); #1;
    in_valid = 1; dividend = 100; divisor = 7; out_ready = 1;
    @(posedge clk); #1;
    in_valid = 0;
    repeat (3) @(posedge clk);
    #1 rst = 1;
    checks++; if (busy !== 1'b1) begin errors++; $display("FAIL mid_busy got=%b exp=1", busy); end
    @(posedge clk); #1;
    rst = 0;
    @(negedge clk);
    checks++; if (out_valid !== 1'b0 || in_ready !== 1'b1 || busy !== 1'b0 || {quotient, remainder, div_by_zero} !== '0) begin errors++;
      $display("FAIL mid_reset got v=%b rdy=%b busy=%b q=%0d r=%0d z=%b exp all idle zero", out_valid, in_ready, busy, quotient, remainder, div_by_zero); end
    seen = 0;
    repeat (15) begin @(negedge clk); if (out_valid) seen = 1; end
    checks++; if (seen) begin errors++; $display("FAIL mid_no_result got out_valid=1 exp=0"); end
    run_op(100, 7, q, r, z, lat, to);
    checks++; if (to || q !== 8'd14 || r !== 8'd2 || z !== 1'b0) begin errors++;
      $display("FAIL mid_next got q=%0d r=%0d z=%b to=%b exp q=14 r=2 z=0", q, r, z, to); end
  endtask

  task automatic test_random;
    localparam int N = 2000;
    logic [W-1:0] eq [$], er [$];
    logic ez [$];
    logic [W-1:0] a, b;
    int sent, got, cyc, bad;
    bit acc;
    sent = 0; got = 0; cyc = 0; bad = 0; acc = 0;
    in_valid = 0;
    while (got < N && cyc < 60000) begin
      @(posedge clk); #1;
      cyc++;
      if (acc) begin in_valid = 0; acc = 0; end
      if (!in_valid && sent < N && $urandom % 3 != 0) begin
        a = W'($urandom);
        b = ($urandom % 8 == 0) ? '0 : (($urandom % 2 == 1) ? W'($urandom % 16) : W'($urandom));
        in_valid = 1; dividend = a; divisor = b;
      end
      out_ready = ($urandom % 4 != 0);
      @(negedge clk);
      if (in_valid && in_ready) begin
        acc = 1; sent++;
        eq.push_back(divisor == 0 ? '1 : dividend / divisor);
        er.push_back(divisor == 0 ? dividend : dividend % divisor);
        ez.push_back(divisor == 0);
      end
      if (out_valid && out_ready) begin
        got++;
        checks++;
        if (eq.size() == 0) begin errors++; $display("FAIL rnd_extra result q=%0d r=%0d with none outstanding", quotient, remainder); end
        else begin
          a = eq.pop_front(); b = er.pop_front();
          if (quotient !== a || remainder !== b || div_by_zero !== ez.pop_front()) begin
            errors++; bad++;
            if (bad < 10) $display("FAIL rnd_result #%0d got q=%0d r=%0d z=%b exp q=%0d r=%0d", got, quotient, remainder, div_by_zero, a, b);
          end
        end
      end
    end
    in_valid = 0;
    checks++; if (got != N || eq.size() != 0) begin errors++;
      $display("FAIL rnd_count got=%0d results, %0d outstanding exp=%0d, 0", got, eq.size(), N); end
  endtask

  initial begin
    test_reset;
    test_directed;
    test_div_zero;
    test_backpressure;
    test_reset_mid;
    test_random;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
